resource_requester: RTL
=======================

// Module: resource_requester
// PURPOSE
//  Initiator side of the shared-resource interface. Accepts one pipeline read request
//  at a time, drives address and a fresh tag to the shared resource, and holds them there.
//  Discards any response whose id does not match the tag, returns matching data upstream,
//  and asserts stall while a request is outstanding. Sits between the pipeline stage
//  and the shared resource in the pipelined_stall design.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in WAIT before an error response; must be >= 2*(`RESOURCE_DELAY+2)
//  Widths come from defines.vh: `ADDRESS_WIDTH, `ID_WIDTH, `DATA_WIDTH.
// PORTS
//  clk           in   1                 clock, all logic on posedge
//  reset         in   1                 asynchronous, active-high reset
//  req_valid     in   1                 upstream request present
//  req_address   in   `ADDRESS_WIDTH    upstream request address
//  req_ready     out  1                 high when a request can be accepted (IDLE)
//  resp_valid    out  1                 one-cycle pulse, response to upstream
//  resp_data     out  `DATA_WIDTH       response data, valid with resp_valid
//  resp_error    out  1                 with resp_valid: request timed out
//  stall         out  1                 pipeline stall, high while in WAIT
//  res_address   out  `ADDRESS_WIDTH    address to shared resource
//  res_id        out  `ID_WIDTH         tag to shared resource
//  res_data      in   `DATA_WIDTH       data from shared resource
//  res_id_in     in   `ID_WIDTH         id returned by shared resource
//  res_valid     in   1                 response valid from shared resource
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 (comb from state); resp_valid=0; resp_data=0; resp_error=0;
//    stall=0; res_address=0; res_id=0; next_tag=1; timer=0.
//  - Outputs are registered except req_ready and stall, which decode state combinationally.
//  - Tag 0 is reserved for idle. res_id=0 in IDLE, so no issued tag ever equals 0.
//  - IDLE: on req_valid&&req_ready, latch req_address. Drive res_address=req_address and
//    res_id=next_tag on the next cycle. timer<=0. Go to WAIT.
//  - WAIT: res_address and res_id are held constant, because the resource samples them
//    without a handshake.
//    * res_valid && res_id_in==res_id: resp_data<=res_data, resp_error<=0, and resp_valid
//      pulses on the next cycle. next_tag<=next_tag+1, wrapping max->1 (skips 0).
//      res_address and res_id go to 0. Go to IDLE.
//    * res_valid && mismatch: stale response. Discard it, stay in WAIT, timer keeps counting.
//    * timer==TIMEOUT_CYCLES-1 with no match: resp_valid=1, resp_error=1, resp_data=0.
//      next_tag advances as above. Go to IDLE.
//    * A match and a timeout in the same cycle: the match wins (no error).
//  - resp_valid is high for exactly one cycle per accepted request, in the cycle after
//    the FSM re-enters IDLE. A new request can be accepted in that same cycle.
//  - Latency, request accept to resp_valid: the resource response time + 2 cycles.
//    Worst case is about 2*(`RESOURCE_DELAY+2)+2, because the first sample may be stale.
//  - req_valid in WAIT is ignored. Upstream must hold it until req_ready.
//  - timer is clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.
//  - Reset mid-WAIT: drops the request immediately, no response. next_tag returns to 1.
// TESTING (pair with shared_resource, `RESOURCE_DELAY=4, ID_WIDTH=3 unless noted)
//  1. Reset, then req addr 5'd3 -> resp_valid pulse once, resp_data=32'h203, resp_error=0,
//     res_id=1 during WAIT, stall high throughout WAIT.
//  2. First request right after reset, while the resource returns id 0 first -> the id 0
//     response is discarded and the response with id 1 is returned (data=addr+512).
//  3. Back-to-back req 5'd1 then 5'd31, req_valid held -> tags 1,2 in order;
//     resp_data 32'h201 then 32'h21F; second request accepted in the cycle resp_valid pulses.
//  4. Eight sequential requests -> tags 1..7 then 1 (0 never driven while in WAIT).
//  5. res_valid tied 0, TIMEOUT_CYCLES=64 -> exactly 64 cycles after WAIT entry:
//     resp_valid=1, resp_error=1, resp_data=0; back in IDLE.
//  6. Assert reset 3 cycles into WAIT -> next cycle all outputs 0, req_ready=1; the next
//     request uses tag 1.

Source files
------------

// File: rtl/resource_requester.sv
// Initiator side of the shared-resource interface: issues one tagged read at a time,
// filters stale responses by id, and stalls the pipeline while the read is outstanding.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 5
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module resource_requester #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic [`ADDRESS_WIDTH-1:0] req_address,
   output logic                      req_ready,
   output logic                      resp_valid,
   output logic [`DATA_WIDTH-1:0]    resp_data,
   output logic                      resp_error,
   output logic                      stall,
   output logic [`ADDRESS_WIDTH-1:0] res_address,
   output logic [`ID_WIDTH-1:0]      res_id,
   input  logic [`DATA_WIDTH-1:0]    res_data,
   input  logic [`ID_WIDTH-1:0]      res_id_in,
   input  logic                      res_valid
);

   localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = '1;
   localparam logic [`ID_WIDTH-1:0]   TAG_FIRST  = `ID_WIDTH'(1);
   localparam logic [`ID_WIDTH-1:0]   TAG_MAX    = '1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   accept;
   logic                   match;
   logic                   timed_out;
   logic [TIMER_WIDTH-1:0] timer;
   logic [`ID_WIDTH-1:0]   next_tag;

   assign req_ready = (state == IDLE);
   assign stall     = (state == WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A matching response beats a timeout landing in the same cycle.
   always_comb begin
      accept     = 1'b0;
      match      = 1'b0;
      timed_out  = 1'b0;
      state_next = state;
      case (state)
         IDLE: begin
            accept = req_valid;
            if (req_valid) state_next = WAIT;
         end
         WAIT: begin
            match     = res_valid && (res_id_in == res_id);
            timed_out = !match && (timer == TIMER_LAST);
            if (match || timed_out) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Address and tag stay frozen through WAIT since the resource samples them unhandshaked;
   // tag 0 is skipped on wrap so it can mean "idle" on res_id.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_error  <= 1'b0;
         res_address <= '0;
         res_id      <= '0;
         next_tag    <= TAG_FIRST;
         timer       <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (accept) begin
            res_address <= req_address;
            res_id      <= next_tag;
            timer       <= '0;
         end else if (state == WAIT) begin
            if (match || timed_out) begin
               resp_valid  <= 1'b1;
               resp_data   <= match ? res_data : '0;
               resp_error  <= !match;
               next_tag    <= (next_tag == TAG_MAX) ? TAG_FIRST : next_tag + 1'b1;
               res_address <= '0;
               res_id      <= '0;
            end else if (timer != TIMER_MAX) begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

endmodule
